// File: rtl/tt_um_mmss_scan_display.sv
// tt_um_mmss_scan_display: mm:ss BCD time counter driving a four-digit multiplexed seven-segment display
module tt_um_mmss_scan_display #(
  parameter int PRESCALE_MAX = 9_999_999,
  parameter int SCAN_DIV = 10_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  logic [23:0] pc_q, pc_d;
  logic [15:0] sc_q, sc_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] s1_q, s10_q, m1_q, m10_q, s1_d, s10_d, m1_d, m10_d, digit;
  logic [7:0] uo_d, uio_d;
  logic pause, clear, fast, pc_end, sc_end, c0, c1, c2, c3, unused_ok;
  assign pause = ui_in[0];
  assign clear = ui_in[1];
  assign fast = ui_in[2];
  assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:3]};
  assign uio_oe = 8'h0F;
  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: enc = 7'h3F;
      4'd1: enc = 7'h06;
      4'd2: enc = 7'h5B;
      4'd3: enc = 7'h4F;
      4'd4: enc = 7'h66;
      4'd5: enc = 7'h6D;
      4'd6: enc = 7'h7D;
      4'd7: enc = 7'h07;
      4'd8: enc = 7'h7F;
      4'd9: enc = 7'h6F;
      default: enc = 7'h00;
    endcase
  endfunction
  // Carry chain: each digit advances only when every lower digit wraps on this tick.
  always_comb begin
    pc_end = pc_q == 24'(PRESCALE_MAX);
    c0 = !clear && !pause && (fast || pc_end);
    c1 = c0 && s1_q == 4'd9;
    c2 = c1 && s10_q == 4'd5;
    c3 = c2 && m1_q == 4'd9;
    pc_d = clear || c0 ? '0 : pause ? pc_q : pc_q + 24'd1;
    s1_d = clear ? '0 : !c0 ? s1_q : c1 ? '0 : s1_q + 4'd1;
    s10_d = clear ? '0 : !c1 ? s10_q : c2 ? '0 : s10_q + 4'd1;
    m1_d = clear ? '0 : !c2 ? m1_q : c3 ? '0 : m1_q + 4'd1;
    m10_d = clear ? '0 : !c3 ? m10_q : m10_q == 4'd5 ? '0 : m10_q + 4'd1;
    sc_end = sc_q == 16'(SCAN_DIV - 1);
    sc_d = sc_end ? '0 : sc_q + 16'd1;
    idx_d = sc_end ? idx_q + 2'd1 : idx_q;
    digit = idx_q == 2'd0 ? s1_q : idx_q == 2'd1 ? s10_q : idx_q == 2'd2 ? m1_q : m10_q;
    uo_d = {fast || pc_q <= 24'(PRESCALE_MAX / 2), enc(digit)};
    uio_d = {4'h0, 4'b0001 << idx_q};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= '0;
      sc_q <= '0;
      idx_q <= '0;
      s1_q <= '0;
      s10_q <= '0;
      m1_q <= '0;
      m10_q <= '0;
      uo_out <= '0;
      uio_out <= '0;
    end else begin
      pc_q <= pc_d;
      sc_q <= sc_d;
      idx_q <= idx_d;
      s1_q <= s1_d;
      s10_q <= s10_d;
      m1_q <= m1_d;
      m10_q <= m10_d;
      uo_out <= uo_d;
      uio_out <= uio_d;
    end
  end
endmodule

// File: tb/tb_tt_um_mmss_scan_display.sv
// tb_tt_um_mmss_scan_display: scoreboard bench comparing the scan display against a seconds-count reference model
module tb_tt_um_mmss_scan_display;
  localparam int PM = 9;
  localparam int SD = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;
  int n_chk = 0;
  int n_fail = 0;
  int cyc_n = 0;
  logic [15:0] exp_q[$];
  logic [15:0] e;
  bit started = 0;
  int secs, pc, scnt, m_idx;
  int dg[4];
  logic colon;
  logic [6:0] seg_tab[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [7:0] u;

  tt_um_mmss_scan_display #(.PRESCALE_MAX(PM), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  // Reference: time as total seconds, scan position from cycles since reset.
  always @(posedge clk) begin
    cyc_n++;
    if (!rst_n) begin
      started = 1;
      exp_q.push_back(16'h0000);
      secs = 0;
      pc = 0;
      scnt = 0;
    end else if (started) begin
      m_idx = (scnt / SD) % 4;
      dg[0] = secs % 10;
      dg[1] = (secs / 10) % 6;
      dg[2] = (secs / 60) % 10;
      dg[3] = secs / 600;
      colon = ui_in[2] || pc <= PM / 2;
      exp_q.push_back({colon, seg_tab[dg[m_idx]], 8'(1 << m_idx)});
      scnt++;
      if (ui_in[1]) begin
        secs = 0;
        pc = 0;
      end else if (!ui_in[0]) begin
        if (ui_in[2] || pc == PM) begin
          secs = (secs + 1) % 3600;
          pc = 0;
        end else pc++;
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %02h expected %02h", name, cyc_n, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard_empty cycle %0d: got 0 entries expected 1", cyc_n);
      end else begin
        e = exp_q.pop_front();
        check("uo_out", uo_out, e[15:8]);
        check("uio_out", uio_out, e[7:0]);
        check("uio_oe", uio_oe, 8'h0F);
      end
    end
  end

  task automatic cyc(input int n, input logic [7:0] ui, input logic r = 1'b1);
    repeat (n) begin
      @(negedge clk);
      rst_n = r;
      ui_in = ui;
      uio_in = 8'($urandom);
      ena = 1'($urandom);
    end
  endtask

  initial begin
    cyc(2, 8'h00, 1'b0);
    cyc(40, 8'h00);
    cyc(3600, 8'h04);
    cyc(1, 8'h02);
    cyc(7, 8'h04);
    cyc(100, 8'h01);
    cyc(1, 8'h06);
    cyc(1, 8'h04);
    cyc(3, 8'h00);
    cyc(1, 8'h02);
    cyc(754, 8'h04);
    cyc(1, 8'h04, 1'b0);
    cyc(20, 8'h00);
    repeat (3000) begin
      u = 8'($urandom);
      u[0] = $urandom_range(0, 7) == 0;
      u[1] = $urandom_range(0, 31) == 0;
      u[2] = $urandom_range(0, 3) != 0;
      cyc(1, u, 1'($urandom_range(0, 299) != 0));
    end
    cyc(4, 8'h00);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
